// File: rtl/pad_cfg_arbiter.sv
// Round-robin arbiter for single-pad configuration writes with a post-write settle interval.
// Holds the full N_IO x NBIT_PADCFG pad configuration state.
//
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   req_valid_i/ready_o : per-requester handshake; at most one ready bit is high
//   req_pad_i/cfg_i     : per-requester target pad index and new configuration
//   req_lock_i          : lock the pad after the write (only with PAD_CFG_LOCK_EN)
//   pad_cfg_o           : configuration of all pads, pad p at [p*NBIT_PADCFG +: NBIT_PADCFG]
//   cfg_update_o        : one-cycle pulse after a successful write
//   err_o               : one-cycle pulse after a rejected write
//   busy_o              : high while the settle interval runs
//
// Optional feature macro: PAD_CFG_LOCK_EN adds a per-pad sticky lock register.
module pad_cfg_arbiter #(
    parameter int N_IO        = 48,
    parameter int NBIT_PADCFG = 6,
    parameter int N_REQ       = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int IDXW        = $clog2(N_IO)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_REQ-1:0]             req_valid_i,
    output logic [N_REQ-1:0]             req_ready_o,
    input  logic [N_REQ*IDXW-1:0]        req_pad_i,
    input  logic [N_REQ*NBIT_PADCFG-1:0] req_cfg_i,
    input  logic [N_REQ-1:0]             req_lock_i,
    output logic [N_IO*NBIT_PADCFG-1:0]  pad_cfg_o,
    output logic                         cfg_update_o,
    output logic                         err_o,
    output logic                         busy_o
);

    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        S_IDLE,
        S_SETTLE
    } state_t;

    state_t                 state;
    logic [7:0]             cnt;
    logic [LW-1:0]          last_q;
    logic [NBIT_PADCFG-1:0] cfg_q [N_IO];

    logic [LW-1:0]          win;
    logic                   any_valid;
    logic                   hs;
    logic [IDXW-1:0]        win_pad;
    logic [NBIT_PADCFG-1:0] win_cfg;
    logic                   in_range;
    logic                   wr_ok;

    // Search upward from last+1; iterating from the far end lets the
    // nearest valid requester overwrite earlier candidates.
    always_comb begin
        int idx;
        idx       = 0;
        win       = last_q;
        any_valid = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_q) + k) % N_REQ;
            if (req_valid_i[idx]) begin
                win       = LW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (!rst_i && state == S_IDLE && any_valid) begin
            req_ready_o[win] = 1'b1;
        end
    end

    assign hs      = |req_ready_o;
    assign win_pad = req_pad_i[int'(win)*IDXW +: IDXW];
    assign win_cfg = req_cfg_i[int'(win)*NBIT_PADCFG +: NBIT_PADCFG];

    // Extra top bit keeps the bound correct when N_IO is a power of two.
    assign in_range = {1'b0, win_pad} < (IDXW+1)'(N_IO);

`ifdef PAD_CFG_LOCK_EN
    logic [N_IO-1:0] lock_q;
    logic            pad_locked;

    always_comb begin
        pad_locked = 1'b0;
        for (int p = 0; p < N_IO; p++) begin
            if (win_pad == IDXW'(p)) begin
                pad_locked = lock_q[p];
            end
        end
    end

    assign wr_ok = in_range && !pad_locked;
`else
    logic lock_unused;
    assign lock_unused = ^req_lock_i;
    assign wr_ok       = in_range;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            cnt          <= '0;
            last_q       <= LW'(N_REQ-1);
            cfg_update_o <= 1'b0;
            err_o        <= 1'b0;
            busy_o       <= 1'b0;
            for (int p = 0; p < N_IO; p++) begin
                cfg_q[p] <= '0;
            end
`ifdef PAD_CFG_LOCK_EN
            lock_q       <= '0;
`endif
        end else begin
            cfg_update_o <= 1'b0;
            err_o        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        last_q <= win;
                        if (wr_ok) begin
                            cfg_update_o <= 1'b1;
                            for (int p = 0; p < N_IO; p++) begin
                                if (win_pad == IDXW'(p)) begin
                                    cfg_q[p] <= win_cfg;
`ifdef PAD_CFG_LOCK_EN
                                    if (req_lock_i[win]) begin
                                        lock_q[p] <= 1'b1;
                                    end
`endif
                                end
                            end
                            if (SETTLE_CYC > 0) begin
                                state  <= S_SETTLE;
                                cnt    <= 8'(SETTLE_CYC);
                                busy_o <= 1'b1;
                            end
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    for (genvar p = 0; p < N_IO; p++) begin : g_out
        assign pad_cfg_o[p*NBIT_PADCFG +: NBIT_PADCFG] = cfg_q[p];
    end

endmodule

// File: tb/tb_pad_cfg_arbiter.sv
// Directed testbench for pad_cfg_arbiter.
// u0 uses SETTLE_CYC=4, u1 uses SETTLE_CYC=0 for back-to-back writes.
module tb_pad_cfg_arbiter;

    localparam int N_IO = 48;
    localparam int NB   = 6;
    localparam int NR   = 2;
    localparam int IW   = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;

    logic [NR-1:0]       v0, rdy0, lk0;
    logic [NR*IW-1:0]    pad0;
    logic [NR*NB-1:0]    cfg0;
    logic [N_IO*NB-1:0]  pc0;
    logic                upd0, err0, busy0;

    logic [NR-1:0]       v1, rdy1, lk1;
    logic [NR*IW-1:0]    pad1;
    logic [NR*NB-1:0]    cfg1;
    logic [N_IO*NB-1:0]  pc1;
    logic                upd1, err1, busy1;

    int checks = 0;
    int errors = 0;

    pad_cfg_arbiter #(
        .N_IO(N_IO), .NBIT_PADCFG(NB), .N_REQ(NR), .SETTLE_CYC(4)
    ) u0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(v0), .req_ready_o(rdy0),
        .req_pad_i(pad0), .req_cfg_i(cfg0), .req_lock_i(lk0),
        .pad_cfg_o(pc0), .cfg_update_o(upd0), .err_o(err0), .busy_o(busy0)
    );

    pad_cfg_arbiter #(
        .N_IO(N_IO), .NBIT_PADCFG(NB), .N_REQ(NR), .SETTLE_CYC(0)
    ) u1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(v1), .req_ready_o(rdy1),
        .req_pad_i(pad1), .req_cfg_i(cfg1), .req_lock_i(lk1),
        .pad_cfg_o(pc1), .cfg_update_o(upd1), .err_o(err1), .busy_o(busy1)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NB-1:0] slc0(input int p);
        return pc0[p*NB +: NB];
    endfunction

    function automatic logic [NB-1:0] slc1(input int p);
        return pc1[p*NB +: NB];
    endfunction

    task automatic set0(input int r, input logic v, input int pad,
                        input logic [NB-1:0] c, input logic l);
        v0[r]            = v;
        pad0[r*IW +: IW] = IW'(pad);
        cfg0[r*NB +: NB] = c;
        lk0[r]           = l;
    endtask

    task automatic wait_grant(output int w);
        w = -1;
        #1;
        for (int n = 0; n < 20; n++) begin
            if (!$onehot0(rdy0)) check("onehot", 64'(rdy0), 64'd1);
            if (rdy0 != '0) begin
                w = rdy0[1] ? 1 : 0;
                return;
            end
            tick();
        end
        check("grant_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int w;
        rst  = 1'b1;
        v0   = '0; lk0 = '0; pad0 = '0; cfg0 = '0;
        v1   = '0; lk1 = '0; pad1 = '0; cfg1 = '0;

        // reset state, with a request already pending
        set0(0, 1'b1, 5, 6'h2A, 1'b0);
        tick();
        tick();
        check("rst_ready", 64'(rdy0), 64'd0);
        check("rst_upd", 64'(upd0), 64'd0);
        check("rst_err", 64'(err0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_cfg", 64'(|pc0), 64'd0);

        // single write and settle timing
        rst = 1'b0;
        #1;
        check("w1_ready", 64'(rdy0), 64'd1);
        tick();
        check("w1_slice", 64'(pc0[35:30]), 64'h2A);
        check("w1_upd", 64'(upd0), 64'd1);
        check("w1_busy0", 64'(busy0), 64'd1);
        check("w1_rdy_settle", 64'(rdy0), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("w1_busy", 64'(busy0), 64'd1);
            check("w1_upd_low", 64'(upd0), 64'd0);
        end
        tick();
        check("w1_busy_end", 64'(busy0), 64'd0);
        check("w1_ready_again", 64'(rdy0), 64'd1);
        v0 = '0;

        // round-robin with both requesters valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set0(0, 1'b1, 1, 6'h11, 1'b0);
        set0(1, 1'b1, 2, 6'h22, 1'b0);
        for (int g = 0; g < 4; g++) begin
            wait_grant(w);
            check("rr_grant", 64'(w), 64'(g % 2));
            tick();
        end
        v0 = '0;
        check("rr_pad1", 64'(slc0(1)), 64'h11);
        check("rr_pad2", 64'(slc0(2)), 64'h22);
        repeat (5) tick();

        // bad index is rejected, next request accepted on the next edge
        set0(0, 1'b1, 48, 6'h3F, 1'b0);
        set0(1, 1'b1, 3, 6'h33, 1'b0);
        #1;
        check("bad_ready", 64'(rdy0), 64'd1);
        tick();
        check("bad_err", 64'(err0), 64'd1);
        check("bad_upd", 64'(upd0), 64'd0);
        check("bad_busy", 64'(busy0), 64'd0);
        check("bad_pad1", 64'(slc0(1)), 64'h11);
        check("bad_pad3", 64'(slc0(3)), 64'h00);
        v0[0] = 1'b0;
        #1;
        check("bad_next_ready", 64'(rdy0), 64'd2);
        tick();
        check("bad_next_upd", 64'(upd0), 64'd1);
        check("bad_next_err", 64'(err0), 64'd0);
        check("bad_next_pad3", 64'(slc0(3)), 64'h33);
        v0 = '0;
        repeat (5) tick();

        // SETTLE_CYC = 0: one write per cycle over all pads
        for (int p = 0; p < N_IO; p++) begin
            v1[0]     = 1'b1;
            pad1[0 +: IW] = IW'(p);
            cfg1[0 +: NB] = NB'(p) ^ 6'h15;
            #1;
            check("b2b_ready", 64'(rdy1), 64'd1);
            tick();
            check("b2b_upd", 64'(upd1), 64'd1);
            check("b2b_busy", 64'(busy1), 64'd0);
        end
        v1 = '0;
        for (int p = 0; p < N_IO; p++) begin
            check("b2b_slice", 64'(slc1(p)), 64'(NB'(p) ^ 6'h15));
        end

`ifdef PAD_CFG_LOCK_EN
        // locked pad rejects later writes until reset
        set0(0, 1'b1, 2, 6'h01, 1'b1);
        tick();
        v0 = '0;
        check("lk_set", 64'(slc0(2)), 64'h01);
        repeat (5) tick();
        set0(0, 1'b1, 2, 6'h3F, 1'b0);
        #1;
        check("lk_ready", 64'(rdy0), 64'd1);
        tick();
        check("lk_err", 64'(err0), 64'd1);
        check("lk_upd", 64'(upd0), 64'd0);
        check("lk_keep", 64'(slc0(2)), 64'h01);
        v0 = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set0(0, 1'b1, 2, 6'h3F, 1'b0);
        tick();
        check("lk_rst_upd", 64'(upd0), 64'd1);
        check("lk_rst_slice", 64'(slc0(2)), 64'h3F);
        v0 = '0;
        repeat (5) tick();
`endif

        // reset in mid-settle
        set0(1, 1'b1, 4, 6'h0A, 1'b0);
        #1;
        check("ms_ready", 64'(rdy0), 64'd2);
        tick();
        check("ms_busy", 64'(busy0), 64'd1);
        set0(1, 1'b1, 6, 6'h16, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check("ms_cfg", 64'(|pc0), 64'd0);
        check("ms_busy_rst", 64'(busy0), 64'd0);
        check("ms_upd_rst", 64'(upd0), 64'd0);
        check("ms_err_rst", 64'(err0), 64'd0);
        check("ms_rdy_rst", 64'(rdy0), 64'd0);
        rst = 1'b0;
        #1;
        check("ms_req1_first", 64'(rdy0), 64'd2);
        tick();
        check("ms_req1_pad6", 64'(slc0(6)), 64'h16);
        set0(0, 1'b1, 7, 6'h07, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("ms_req0_wins", 64'(rdy0), 64'd1);
        v0 = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
